// File: rtl/mul_pkg.sv
// mul_pkg: shared state encoding and default sizing for the multiplier controller
package mul_pkg;
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, COMPUTE, DONE, ERR} state_t;
  localparam int CNT_W_DEF = 32;
  localparam logic [CNT_W_DEF-1:0] MAX_ITER_DEF = '1;
endpackage

// File: rtl/mul_if.sv
// mul_if: controller-side handshake, datapath strobes and status
interface mul_if;
  logic start, data_valid, data_ready, eqz, ack;
  logic LdA, LdB, LdP, clrA, clrP, decB, busy, done, err;
  modport master (
    input  start, data_valid, eqz, ack,
    output data_ready, LdA, LdB, LdP, clrA, clrP, decB, busy, done, err
  );
  modport slave (
    output start, data_valid, eqz, ack,
    input  data_ready, LdA, LdB, LdP, clrA, clrP, decB, busy, done, err
  );
endinterface

// File: rtl/mul_iter_wdog.sv
// mul_iter_wdog: clearable saturating iteration counter with terminal flag
module mul_iter_wdog import mul_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF,
  parameter logic [CNT_W-1:0] MAX_ITER = CNT_W'(MAX_ITER_DEF)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic term
);
  logic [CNT_W-1:0] cnt;
  assign term = cnt == MAX_ITER;
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en && !term) cnt <= cnt + CNT_W'(1);
  end
endmodule

// File: rtl/mul_controller.sv
// mul_controller: FSM sequencing the repeated-addition multiplier datapath
module mul_controller import mul_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF,
  parameter logic [CNT_W-1:0] MAX_ITER = CNT_W'(MAX_ITER_DEF)
) (
  input logic clk,
  input logic rst,
  mul_if.master bus
);
  state_t state, nxt;
  logic term, run;
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = bus.start ? LOAD_A : IDLE;
      LOAD_A:  nxt = bus.data_valid ? LOAD_B : LOAD_A;
      LOAD_B:  nxt = bus.data_valid ? COMPUTE : LOAD_B;
      COMPUTE: nxt = bus.eqz ? DONE : term ? ERR : COMPUTE;
      DONE:    nxt = bus.ack ? IDLE : DONE;
      ERR:     nxt = bus.ack ? IDLE : ERR;
      default: nxt = IDLE;
    endcase
  end
  // every output is forced low during a reset cycle, whatever the state
  always_comb begin
    run = !rst;
    bus.data_ready = run && (state == LOAD_A || state == LOAD_B);
    bus.clrA = run && state == IDLE && bus.start;
    bus.clrP = bus.clrA;
    bus.LdA = run && state == LOAD_A && bus.data_valid;
    bus.LdB = run && state == LOAD_B && bus.data_valid;
    bus.LdP = run && state == COMPUTE && !bus.eqz && !term;
    bus.decB = bus.LdP;
    bus.busy = run && state != IDLE;
    bus.done = run && state == DONE;
    bus.err = run && state == ERR;
  end
  mul_iter_wdog #(.CNT_W(CNT_W), .MAX_ITER(MAX_ITER)) u_wdog (
    .clk(clk),
    .rst(rst),
    .clr(bus.LdB),
    .en(bus.LdP),
    .term(term)
  );
endmodule

// File: tb/tb_mul_controller.sv
// tb_mul_controller: randomized check of two controllers (default and tiny watchdog) against a datapath model
module tb_mul_controller;
  localparam int WD = 4;
  localparam int RDY = 9, LDA = 8, LDB = 7, LDP = 6, CLRA = 5, CLRP = 4, DECB = 3, BUSY = 2, DONE = 1, ERR = 0;
  logic clk = 0, rst = 1, start = 0, data_valid = 0, ack = 0, force0 = 0;
  int din = 0;
  int checks = 0, errors = 0;
  int a_r[2] = '{0, 0}, b_r[2] = '{0, 0}, p_r[2] = '{0, 0}, lpc[2] = '{0, 0};
  logic [9:0] o [2];
  mul_if b0 ();
  mul_if b1 ();
  mul_controller u0 (.clk(clk), .rst(rst), .bus(b0));
  mul_controller #(.CNT_W(8), .MAX_ITER(8'(WD))) u1 (.clk(clk), .rst(rst), .bus(b1));
  always #5 clk = ~clk;
  assign b0.start = start;
  assign b1.start = start;
  assign b0.data_valid = data_valid;
  assign b1.data_valid = data_valid;
  assign b0.ack = ack;
  assign b1.ack = ack;
  assign b0.eqz = !force0 && b_r[0] == 0;
  assign b1.eqz = !force0 && b_r[1] == 0;
  assign o[0] = {b0.data_ready, b0.LdA, b0.LdB, b0.LdP, b0.clrA, b0.clrP, b0.decB, b0.busy, b0.done, b0.err};
  assign o[1] = {b1.data_ready, b1.LdA, b1.LdB, b1.LdP, b1.clrA, b1.clrP, b1.decB, b1.busy, b1.done, b1.err};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // behavioural datapath: A, P and the B down-counter react to the strobes
  always @(posedge clk)
    for (int i = 0; i < 2; i++) begin
      if (o[i][CLRA]) a_r[i] <= 0;
      if (o[i][CLRP]) begin p_r[i] <= 0; lpc[i] <= 0; end
      if (o[i][LDA]) a_r[i] <= din;
      if (o[i][LDB]) b_r[i] <= din;
      if (o[i][LDP]) begin p_r[i] <= p_r[i] + a_r[i]; lpc[i] <= lpc[i] + 1; end
      if (o[i][DECB]) b_r[i] <= b_r[i] - 1;
    end

  always @(negedge clk)
    for (int i = 0; i < 2; i++) begin
      chk("excl", 32'($countones({o[i][LDA], o[i][LDB], o[i][LDP] | o[i][DECB], o[i][CLRA] | o[i][CLRP]}) <= 1), 1);
      chk("pair", {o[i][LDP], o[i][CLRA]}, {o[i][DECB], o[i][CLRP]});
    end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int a, input int b, input int sa, input int sb, input bit poke, input bit wd, input int rst_at);
    int lat[2];
    bit fin[2];
    int n;
    bit e;
    int it;
    start = 1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk("clr", {o[i][CLRA], o[i][CLRP], o[i][BUSY]}, 3'b110);
    cyc;
    start = 0;
    repeat (sa) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) chk("stall_a", {o[i][RDY], o[i][LDA], o[i][BUSY]}, 3'b101);
      cyc;
    end
    data_valid = 1;
    din = a;
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk("lda", {o[i][RDY], o[i][LDA]}, 2'b11);
    cyc;
    data_valid = 0;
    ack = poke;
    repeat (sb) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) chk("stall_b", {o[i][RDY], o[i][LDB], o[i][BUSY]}, 3'b101);
      cyc;
    end
    data_valid = 1;
    din = b;
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk("ldb", {o[i][RDY], o[i][LDB]}, 2'b11);
    cyc;
    data_valid = 0;
    ack = 0;
    fin = '{0, 0};
    lat = '{-1, -1};
    for (it = 0; it < 64 && !(fin[1] && (fin[0] || wd)); it++) begin
      if (poke) start = 1'($urandom_range(0, 1));
      if (it == rst_at) rst = 1;
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < 2; i++) chk("rst_out", o[i], 0);
        cyc;
        rst = 0;
        start = 0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) chk("rst_idle", o[i], 0);
        cyc;
        return;
      end
      for (int i = 0; i < 2; i++)
        if (fin[i]) chk("hold", o[i][DONE] | o[i][ERR], 1);
        else if (o[i][DONE] | o[i][ERR]) begin fin[i] = 1; lat[i] = it; end
      cyc;
    end
    if (!(fin[1] && (fin[0] || wd))) chk("timeout", 0, 1);
    for (int i = wd ? 1 : 0; i < 2; i++) begin
      n = wd ? WD : (i == 0 || b <= WD) ? b : WD;
      e = wd || (i == 1 && b > WD);
      chk("latency", lat[i], n + 1);
      chk("ldp_count", lpc[i], n);
      chk("done", o[i][DONE], !e);
      chk("err", o[i][ERR], e);
      if (!wd) chk("product", p_r[i], a * n);
    end
    ack = 1;
    start = poke;
    cyc;
    ack = 0;
    start = 0;
    @(negedge clk);
    for (int i = wd ? 1 : 0; i < 2; i++) chk("idle", o[i], 0);
    cyc;
  endtask

  initial begin
    repeat (2) cyc;
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk("reset", o[i], 0);
    cyc;
    rst = 0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk("reset_idle", o[i], 0);
    cyc;
    run(5, 3, 0, 0, 0, 0, -1);
    run(7, 0, 0, 0, 0, 0, -1);
    run(11, 6, 4, 2, 0, 0, -1);
    run(2, 4, 1, 1, 0, 0, -1);
    force0 = 1;
    run(3, 2, 0, 0, 0, 1, -1);
    rst = 1;
    cyc;
    rst = 0;
    force0 = 0;
    run(9, 10, 0, 0, 0, 0, 2);
    run(6, 2, 0, 0, 0, 0, -1);
    run(13, 4, 1, 2, 1, 0, -1);
    repeat (30)
      run(int'($urandom_range(0, 255)), int'($urandom_range(0, 8)), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
